multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore control sequencer for a multicycle variant of the MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut regs).
//  Decodes Opcode and steps FETCH->DECODE->execute states, driving every datapath enable/select.
//  Waits on a MemReady handshake for shared memory, with a timeout. Flags illegal opcodes.
// PARAMETERS
//  TIMEOUT_CYCLES  15  max cycles a memory state waits for MemReady before abort (1..255)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  synchronous, active-high reset
//  Opcode       in   6  Instruction[31:26] from IR
//  MemReady     in   1  shared memory completed the current access this cycle
//  PCWrite      out  1  unconditional PC load
//  BranchEQ     out  1  PC load if ALU Zero=1
//  BranchNE     out  1  PC load if ALU Zero=0
//  IorD         out  1  0: memory address=PC; 1: memory address=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  load IR from memory data
//  MemtoReg     out  1  0: write-back ALUOut; 1: MDR
//  RegDst       out  1  0: rt [20:16]; 1: rd [15:11]
//  RegWrite     out  1  register file write enable
//  ALUSrcA      out  1  0: PC; 1: reg A
//  ALUSrcB      out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  PCSource     out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
//  ALUOp        out  3  000 add, 001 sub, 010 R-type funct, 011 or
//  IllegalOp    out  1  one-cycle pulse: unsupported opcode decoded
//  BusError     out  1  one-cycle pulse: memory access timed out
//  State        out  4  current state code (debug)
// BEHAVIOUR
//  - Encodings: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPE=6 RWB=7 BRANCH=8 JUMP=9 IMM=10 IWB=11.
//  - reset=1 at a rising edge: State<=FETCH, wait counter<=0, IllegalOp/BusError<=0.
//    Outputs are Moore decodes of State; after reset all outputs 0 except FETCH set below.
//  - Outputs not listed for a state are 0.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
//    While MemReady=0: stay, counter++, IRWrite=PCWrite=0.
//    MemReady=1: IRWrite=1, PCWrite=1 (same cycle, combinational on MemReady), ->DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Next state by Opcode:
//    0x23 lw / 0x2B sw -> MEMADR; 0x00 -> RTYPE; 0x04 beq / 0x05 bne -> BRANCH;
//    0x02 j -> JUMP; 0x08 addi / 0x0D ori -> IMM.
//    Any other opcode: IllegalOp=1 next cycle, ->FETCH (PC already advanced; instruction skipped).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; ->MEMRD if lw else ->MEMWR.
//  - MEMRD: MemRead=1, IorD=1; wait for MemReady as in FETCH; on MemReady ->MEMWB.
//  - MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; ->FETCH.
//  - MEMWR: MemWrite=1, IorD=1; wait for MemReady; on MemReady ->FETCH.
//  - RTYPE: ALUSrcA=1, ALUSrcB=00, ALUOp=010; ->RWB.
//  - RWB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01.
//    BranchEQ=1 if Opcode=0x04; BranchNE=1 if Opcode=0x05. ->FETCH.
//  - JUMP: PCWrite=1, PCSource=10; ->FETCH.
//  - IMM: ALUSrcA=1, ALUSrcB=10; ALUOp=000 for addi, 011 for ori; ->IWB.
//  - IWB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
//  - Wait counter (8 bit):
//    cleared on entry to any memory state and whenever MemReady=1; increments each waiting cycle.
//    If counter reaches TIMEOUT_CYCLES-1 with MemReady=0: BusError=1 next cycle, ->FETCH.
//    No PC, IR, or register write occurs on timeout. MemReady=1 on that same cycle wins (normal completion).
//  - MemReady is ignored in non-memory states.
//  - reset mid-instruction (any state): next state FETCH; no write enable asserted in the reset cycle.
//  - Latency, zero wait (MemReady=1 on first request cycle):
//    lw 5 cycles; sw, R-type, addi, ori 4 cycles; beq, bne, j 3 cycles.
// TESTING
//  1. Reset, MemReady=1, Opcode=0x00 -> State sequence 0,1,6,7,0.
//     RegWrite=1 and RegDst=1 only in cycle 4; ALUOp=010 in cycle 3.
//  2. Opcode=0x23, MemReady low 3 cycles in MEMRD -> MemRead=IorD=1 held 4 cycles, then MEMWB with MemtoReg=1, RegWrite=1.
//     Total 8 cycles.
//  3. Opcode=0x04 and 0x05 -> BRANCH asserts BranchEQ=1 (resp. BranchNE=1), ALUOp=001, PCSource=01; back to FETCH.
//  4. Opcode=0x3F -> DECODE->FETCH; IllegalOp pulses exactly once; no RegWrite/MemWrite.
//  5. Opcode=0x2B, MemReady held 0 in MEMWR, TIMEOUT_CYCLES=15 -> after 15 MEMWR cycles BusError pulses 1 cycle, State=0.
//     MemWrite deasserts.
//  6. reset=1 asserted while State=MEMWR -> next edge State=0, MemWrite=0; FETCH resumes with MemRead=1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for a multicycle MIPS datapath with a shared memory.
// It waits on the MemReady handshake with a timeout and flags opcodes it cannot execute.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       BranchEQ,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       IllegalOp,
    output logic       BusError,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTYPE  = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMM    = 4'd10,
        IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     nextState;
    logic [7:0] waitCount;
    logic       memState;
    logic       timeout;
    logic       illegalDecode;

    assign State    = state;
    assign memState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign timeout  = memState && !MemReady && (waitCount == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            IllegalOp <= 1'b0;
            BusError  <= 1'b0;
        end else begin
            state     <= nextState;
            IllegalOp <= illegalDecode;
            BusError  <= timeout;
        end
    end

    // The counter restarts whenever the state changes, so every memory state begins its wait at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCount <= 8'd0;
        end else if (MemReady || timeout || (nextState != state)) begin
            waitCount <= 8'd0;
        end else if (memState) begin
            waitCount <= waitCount + 8'd1;
        end
    end

    always_comb begin
        nextState     = state;
        illegalDecode = 1'b0;
        PCWrite       = 1'b0;
        BranchEQ      = 1'b0;
        BranchNE      = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALUOp         = 3'b000;

        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (MemReady) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW:     nextState = MEMADR;
                    OP_RTYPE:         nextState = RTYPE;
                    OP_BEQ, OP_BNE:   nextState = BRANCH;
                    OP_J:             nextState = JUMP;
                    OP_ADDI, OP_ORI:  nextState = IMM;
                    default: begin
                        illegalDecode = 1'b1;
                        nextState     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = (Opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    nextState = MEMWB;
                end else if (timeout) begin
                    nextState = FETCH;
                end
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                nextState = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady || timeout) begin
                    nextState = FETCH;
                end
            end
            RTYPE: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 3'b010;
                nextState = RWB;
            end
            RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 3'b001;
                PCSource  = 2'b01;
                BranchEQ  = (Opcode == OP_BEQ);
                BranchNE  = (Opcode == OP_BNE);
                nextState = FETCH;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                nextState = FETCH;
            end
            IMM: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = (Opcode == OP_ORI) ? 3'b011 : 3'b000;
                nextState = IWB;
            end
            IWB: begin
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase

        // A reset cycle must never commit architectural state, whatever state it interrupts.
        if (reset) begin
            nextState     = FETCH;
            illegalDecode = 1'b0;
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            BranchEQ      = 1'b0;
            BranchNE      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: an instruction-level model predicts the control word of every cycle
// from each instruction's opcode and memory wait lengths, under randomized instruction streams.
module tb_multicycle_control_fsm;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic       pcWrite;
        logic       branchEq;
        logic       branchNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSource;
        logic [2:0] aluOp;
        logic       illegalOp;
        logic       busError;
        logic [3:0] state;
    } ctrl_t;

    logic       clock;
    logic       reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp, BusError;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    ctrl_t obs;
    int    checkCount = 0;
    int    errorCount = 0;
    bit    pendIll = 0;
    bit    pendBus = 0;

    multicycle_control_fsm #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clock), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .BusError(BusError),
        .State(State)
    );

    assign obs = {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, BusError, State};

    // Free-running clock, 10 time units per period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input ctrl_t actual, input ctrl_t expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, required %h (state %0d)", tag, actual, expected, expected.state);
        end
    endtask

    // One clock cycle: drive MemReady, compare at the falling edge, leave just after the rising edge
    task automatic applyStimulus(input string tag, input logic ready, input ctrl_t expected);
        ctrl_t e;
        e = expected;
        e.illegalOp = pendIll;
        e.busError  = pendBus;
        pendIll = 0;
        pendBus = 0;
        MemReady = ready;
        @(negedge clock);
        checkOutput(tag, obs, e);
        @(posedge clock);
        #1;
    endtask

    // A memory access waits 'waits' cycles; reaching the timeout aborts it with a bus error
    task automatic memPhase(input string tag, input ctrl_t waiting, input ctrl_t done,
                            input int waits, output bit ok);
        for (int i = 0; i < waits && i < TIMEOUT; i++) applyStimulus(tag, 1'b0, waiting);
        if (waits >= TIMEOUT) begin
            pendBus = 1;
            ok = 0;
        end else begin
            applyStimulus(tag, 1'b1, done);
            ok = 1;
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input int fetchWait, input int memWait);
        ctrl_t b, d;
        bit ok;
        Opcode = op;
        b = '0; b.memRead = 1; b.aluSrcB = 2'b01;
        d = b; d.irWrite = 1; d.pcWrite = 1;
        memPhase("fetch", b, d, fetchWait, ok);
        if (!ok) return;
        b = '0; b.state = 4'd1; b.aluSrcB = 2'b11;
        applyStimulus("decode", 1'($urandom), b);
        case (op)
            6'h23, 6'h2B: begin
                b = '0; b.state = 4'd2; b.aluSrcA = 1; b.aluSrcB = 2'b10;
                applyStimulus("memadr", 1'($urandom), b);
                b = '0; b.iorD = 1;
                if (op == 6'h23) begin
                    b.state = 4'd3; b.memRead = 1;
                end else begin
                    b.state = 4'd5; b.memWrite = 1;
                end
                memPhase(op == 6'h23 ? "memrd" : "memwr", b, b, memWait, ok);
                if (ok && op == 6'h23) begin
                    b = '0; b.state = 4'd4; b.regWrite = 1; b.memtoReg = 1;
                    applyStimulus("memwb", 1'($urandom), b);
                end
            end
            6'h00: begin
                b = '0; b.state = 4'd6; b.aluSrcA = 1; b.aluOp = 3'b010;
                applyStimulus("rtype", 1'($urandom), b);
                b = '0; b.state = 4'd7; b.regWrite = 1; b.regDst = 1;
                applyStimulus("rwb", 1'($urandom), b);
            end
            6'h04, 6'h05: begin
                b = '0; b.state = 4'd8; b.aluSrcA = 1; b.aluOp = 3'b001; b.pcSource = 2'b01;
                b.branchEq = (op == 6'h04);
                b.branchNe = (op == 6'h05);
                applyStimulus("branch", 1'($urandom), b);
            end
            6'h02: begin
                b = '0; b.state = 4'd9; b.pcWrite = 1; b.pcSource = 2'b10;
                applyStimulus("jump", 1'($urandom), b);
            end
            6'h08, 6'h0D: begin
                b = '0; b.state = 4'd10; b.aluSrcA = 1; b.aluSrcB = 2'b10;
                b.aluOp = (op == 6'h0D) ? 3'b011 : 3'b000;
                applyStimulus("imm", 1'($urandom), b);
                b = '0; b.state = 4'd11; b.regWrite = 1;
                applyStimulus("iwb", 1'($urandom), b);
            end
            default: pendIll = 1;
        endcase
    endtask

    function automatic int pickWait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r < 8) return TIMEOUT - 1;
        return TIMEOUT + $urandom_range(0, 3);
    endfunction

    initial begin
        ctrl_t e;
        logic [5:0] legalOps [8];
        logic [5:0] op;
        legalOps = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};

        reset = 1'b1;
        MemReady = 1'b1;
        Opcode = 6'h00;
        @(posedge clock);
        #1;
        e = '0; e.memRead = 1; e.aluSrcB = 2'b01;
        applyStimulus("reset", 1'b1, e);
        reset = 1'b0;

        runInstr(6'h00, 0, 0);
        runInstr(6'h23, 0, 3);
        runInstr(6'h04, 0, 0);
        runInstr(6'h05, 0, 0);
        runInstr(6'h3F, 0, 0);
        runInstr(6'h2B, 0, TIMEOUT);
        runInstr(6'h23, TIMEOUT - 1, TIMEOUT - 1);

        // Reset arriving in the middle of a stalled store
        Opcode = 6'h2B;
        e = '0; e.memRead = 1; e.aluSrcB = 2'b01; e.irWrite = 1; e.pcWrite = 1;
        applyStimulus("rst_fetch", 1'b1, e);
        e = '0; e.state = 4'd1; e.aluSrcB = 2'b11;
        applyStimulus("rst_decode", 1'b0, e);
        e = '0; e.state = 4'd2; e.aluSrcA = 1; e.aluSrcB = 2'b10;
        applyStimulus("rst_memadr", 1'b0, e);
        e = '0; e.state = 4'd5; e.iorD = 1; e.memWrite = 1;
        applyStimulus("rst_memwr", 1'b0, e);
        reset = 1'b1;
        e.memWrite = 0;
        applyStimulus("rst_cycle", 1'b1, e);
        reset = 1'b0;
        runInstr(6'h08, 2, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) op = legalOps[$urandom_range(0, 7)];
            else op = 6'($urandom_range(6'h30, 6'h3F));
            runInstr(op, pickWait(), pickWait());
        end
        runInstr(6'h0D, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
